// File: rtl/cacheline_adaptor.sv
// Cache-line to burst adaptor: turns one 256b line read/write into a single 4-beat
// memory burst, assembling read beats into line_o and serialising write lines onto burst_o.
module cacheline_adaptor #(
    parameter int unsigned LINE_BITS  = 256,
    parameter int unsigned BURST_BITS = 64,
    parameter int unsigned BURSTS     = LINE_BITS / BURST_BITS,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LINE_BITS-1:0]  line_i,
    output logic [LINE_BITS-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic                  read_i,
    input  logic                  write_i,
    output logic                  resp_o,
    input  logic [BURST_BITS-1:0] burst_i,
    output logic [BURST_BITS-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic                  read_o,
    output logic                  write_o,
    input  logic                  resp_i
);

    localparam int unsigned CntW = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam int unsigned OffW = $clog2(LINE_BITS / 8);
    localparam logic [CntW-1:0] LastBeat = CntW'(BURSTS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [LINE_BITS-1:0]    wline_q, wline_d;
    logic [LINE_BITS-1:0]    rline_q, rline_d;
    logic [BURST_BITS-1:0]   burst_q, burst_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    read_q, read_d;
    logic                    write_q, write_d;
    logic                    resp_q, resp_d;
    logic [ADDR_WIDTH-1:0]   aligned_addr;

    assign aligned_addr = {address_i[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wline_d = wline_q;
        rline_d = rline_q;
        burst_d = burst_q;
        addr_d  = addr_q;
        read_d  = read_q;
        write_d = write_q;
        resp_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Write wins when both requests are presented together.
                if (write_i) begin
                    wline_d = line_i;
                    addr_d  = aligned_addr;
                    cnt_d   = '0;
                    write_d = 1'b1;
                    burst_d = line_i[BURST_BITS-1:0];
                    state_d = StWr;
                end else if (read_i) begin
                    addr_d  = aligned_addr;
                    cnt_d   = '0;
                    read_d  = 1'b1;
                    state_d = StRd;
                end
            end
            StRd: begin
                if (resp_i) begin
                    rline_d[int'(cnt_q)*BURST_BITS +: BURST_BITS] = burst_i;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastBeat) begin
                        read_d  = 1'b0;
                        resp_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StWr: begin
                // burst_o only advances once memory has taken the current beat.
                if (resp_i) begin
                    if (cnt_q == LastBeat) begin
                        write_d = 1'b0;
                        resp_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        burst_d = wline_q[(int'(cnt_q) + 1)*BURST_BITS +: BURST_BITS];
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wline_q <= '0;
            rline_q <= '0;
            burst_q <= '0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            resp_q  <= resp_d;
        end
    end

    assign line_o    = rline_q;
    assign burst_o   = burst_q;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;

endmodule
